// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - shared types, error codes and address helpers for the AHB burst checker
//
// Purpose: transfer/burst encodings, checker FSM states, violation codes, and the
// beat-count and next-address functions used by ahb_addr_gen and ahb_burst_checker.
// Ports: none (package).

package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_t;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'd0,
    HBURST_INCR   = 3'd1,
    HBURST_WRAP4  = 3'd2,
    HBURST_INCR4  = 3'd3,
    HBURST_WRAP8  = 3'd4,
    HBURST_INCR8  = 3'd5,
    HBURST_WRAP16 = 3'd6,
    HBURST_INCR16 = 3'd7
  } hburst_t;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } chk_state_t;

  localparam logic [2:0] ERR_SEQ_NO_BURST  = 3'd1;
  localparam logic [2:0] ERR_EARLY_TERM    = 3'd2;
  localparam logic [2:0] ERR_ADDR_MISMATCH = 3'd3;
  localparam logic [2:0] ERR_CTRL_CHANGE   = 3'd4;
  localparam logic [2:0] ERR_UNALIGNED     = 3'd5;
  localparam logic [2:0] ERR_SIZE_ILLEGAL  = 3'd6;
  localparam logic [2:0] ERR_BOUNDARY_1K   = 3'd7;

  // WRAP4/8/16 are the even non-zero encodings.
  function automatic logic is_wrap(input logic [2:0] burst);
    return (burst != HBURST_SINGLE) && !burst[0];
  endfunction

  // SINGLE and INCR both report 1; INCR length is open-ended.
  function automatic logic [4:0] burst_beats(input logic [2:0] burst);
    case (burst)
      HBURST_WRAP4, HBURST_INCR4:   return 5'd4;
      HBURST_WRAP8, HBURST_INCR8:   return 5'd8;
      HBURST_WRAP16, HBURST_INCR16: return 5'd16;
      default:                      return 5'd1;
    endcase
  endfunction

  // Largest wrap window is 16 beats x 128 bytes = 2 KB, so only the low 11 address
  // bits take part in wrapping. The result is 12 bits: bit 11 is the carry out of
  // an incrementing step, which the caller propagates into the upper address.
  function automatic logic [11:0] next_addr(input logic [10:0] addr,
                                            input logic [2:0]  size,
                                            input logic [2:0]  burst);
    logic [11:0] inc;
    logic [11:0] sum;
    logic [11:0] mask;
    inc  = 12'd1 << size;
    sum  = {1'b0, addr} + inc;
    mask = ({7'd0, burst_beats(burst)} << size) - 12'd1;
    if (is_wrap(burst)) begin
      return ({1'b0, addr} & ~mask) | (sum & mask);
    end
    return sum;
  endfunction

endpackage

// File: rtl/ahb_addr_gen.sv
// rtl/ahb_addr_gen.sv - combinational next-address generator for INCR and WRAP bursts
//
// Purpose: expected address of the beat following addr for a given size and burst.
// Ports:
//   addr      in  ADDR_W  current beat address
//   size      in  3       transfer size (2^size bytes)
//   burst     in  3       burst type
//   addr_next out ADDR_W  expected address of the next beat

module ahb_addr_gen
  import ahb_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        size,
  input  logic [2:0]        burst,
  output logic [ADDR_W-1:0] addr_next
);

  logic [11:0] low_next;

  assign low_next = next_addr(addr[10:0], size, burst);

  generate
    if (ADDR_W > 11) begin : g_upper
      localparam int UW = ADDR_W - 11;
      logic [UW-1:0] upper;
      // Wrap results never carry, so only incrementing bursts move the upper bits.
      assign upper     = addr[ADDR_W-1:11] + UW'(low_next[11]);
      assign addr_next = {upper, low_next[10:0]};
    end else begin : g_low_only
      assign addr_next = low_next[10:0];
    end
  endgenerate

endmodule

// File: rtl/ahb_burst_checker.sv
// rtl/ahb_burst_checker.sv - passive AHB burst protocol checker with registered error reports
//
// Purpose: tracks each burst (FSM + beat counter), predicts the next address and
// flags protocol violations with a code, offending/expected address and sticky status.
// Ports:
//   clock, Hresetn                  bus clock, async active-low reset
//   Htrans/Hburst/Hsize/Haddr/Hwrite sampled address-phase signals
//   Hreadyout                       slave ready
//   clr_status                      synchronous clear of err_status
//   err_valid/err_code/err_addr/exp_addr  violation pulse and held report
//   err_status                      sticky OR of violation codes
//   burst_done, beat_cnt            completion pulse and beats in current burst

module ahb_burst_checker
  import ahb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              Hresetn,
  input  logic [1:0]        Htrans,
  input  logic [2:0]        Hburst,
  input  logic [2:0]        Hsize,
  input  logic [ADDR_W-1:0] Haddr,
  input  logic              Hwrite,
  input  logic              Hreadyout,
  input  logic              clr_status,
  output logic              err_valid,
  output logic [2:0]        err_code,
  output logic [ADDR_W-1:0] err_addr,
  output logic [ADDR_W-1:0] exp_addr,
  output logic [7:0]        err_status,
  output logic              burst_done,
  output logic [4:0]        beat_cnt
);

  localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_W / 8));

  chk_state_t         state, state_d;
  logic [3:0]         beats_left, beats_left_d;
  logic [2:0]         lat_burst, lat_burst_d, lat_size, lat_size_d;
  logic               lat_write, lat_write_d;
  logic [ADDR_W-1:0]  exp_next, exp_next_d;
  logic [ADDR_W-11:0] burst_hi, burst_hi_d;
  logic [4:0]         cnt_d;
  logic               done_d;

  logic [1:0]         prev_trans;
  logic [ADDR_W-1:0]  prev_addr;
  logic [2:0]         prev_burst, prev_size;
  logic               prev_write, stall_q;

  logic [ADDR_W-1:0]  addr_next;
  logic [4:0]         beats_new;
  logic [6:0]         lsb_mask;
  logic               accept, in_burst, seq_beat, stall_change, seq_ctrl_change;
  logic [7:0]         err_vec;
  logic [2:0]         code_d;

  ahb_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .addr      (Haddr),
    .size      (Hsize),
    .burst     (Hburst),
    .addr_next (addr_next)
  );

  assign accept    = Hreadyout && Htrans[1];
  assign in_burst  = (state == S_BURST);
  assign seq_beat  = accept && (Htrans == HTRANS_SEQ) && in_burst;
  assign beats_new = burst_beats(Hburst);
  assign lsb_mask  = ~(7'h7F << Hsize);

  assign seq_ctrl_change = seq_beat &&
      ((Hburst != lat_burst) || (Hsize != lat_size) || (Hwrite != lat_write));
  // A stalled non-IDLE sample must be presented unchanged on the next edge.
  assign stall_change = stall_q &&
      ((Htrans != prev_trans) || (Haddr != prev_addr) || (Hburst != prev_burst) ||
       (Hsize != prev_size) || (Hwrite != prev_write));

  always_comb begin
    state_d      = state;
    beats_left_d = beats_left;
    lat_burst_d  = lat_burst;
    lat_size_d   = lat_size;
    lat_write_d  = lat_write;
    exp_next_d   = exp_next;
    burst_hi_d   = burst_hi;
    cnt_d        = beat_cnt;
    done_d       = 1'b0;
    if (accept && (Htrans == HTRANS_NONSEQ)) begin
      lat_burst_d  = Hburst;
      lat_size_d   = Hsize;
      lat_write_d  = Hwrite;
      burst_hi_d   = Haddr[ADDR_W-1:10];
      exp_next_d   = addr_next;
      cnt_d        = 5'd1;
      beats_left_d = 4'(beats_new - 5'd1);
      if ((Hburst != HBURST_INCR) && (beats_new == 5'd1)) begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end else begin
        state_d = S_BURST;
      end
    end else if (seq_beat) begin
      exp_next_d = addr_next;
      cnt_d      = (beat_cnt == 5'd31) ? beat_cnt : beat_cnt + 5'd1;
      if (lat_burst != HBURST_INCR) begin
        beats_left_d = beats_left - 4'd1;
        if (beats_left == 4'd1) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
    end else if (Hreadyout && in_burst && (Htrans == HTRANS_IDLE)) begin
      state_d = S_IDLE;
    end
  end

  always_comb begin
    err_vec = 8'd0;
    err_vec[ERR_SEQ_NO_BURST] = Hreadyout && !in_burst &&
        ((Htrans == HTRANS_SEQ) || (Htrans == HTRANS_BUSY));
    err_vec[ERR_EARLY_TERM] = Hreadyout && in_burst && (lat_burst != HBURST_INCR) &&
        (beats_left != 4'd0) && ((Htrans == HTRANS_NONSEQ) || (Htrans == HTRANS_IDLE));
    err_vec[ERR_ADDR_MISMATCH] = seq_beat && (Haddr != exp_next);
    err_vec[ERR_CTRL_CHANGE]   = seq_ctrl_change || stall_change;
    err_vec[ERR_UNALIGNED]     = accept && |(Haddr[6:0] & lsb_mask);
    err_vec[ERR_SIZE_ILLEGAL]  = accept && (Hsize > MAX_SIZE);
    err_vec[ERR_BOUNDARY_1K]   = seq_beat && !is_wrap(lat_burst) &&
        (Haddr[ADDR_W-1:10] != burst_hi);
    code_d = 3'd0;
    for (int i = 7; i >= 1; i--) begin
      if (err_vec[i]) code_d = 3'(i);
    end
  end

  always_ff @(posedge clock or negedge Hresetn) begin
    if (!Hresetn) begin
      state      <= S_IDLE;
      beats_left <= '0;
      lat_burst  <= '0;
      lat_size   <= '0;
      lat_write  <= 1'b0;
      exp_next   <= '0;
      burst_hi   <= '0;
      beat_cnt   <= '0;
      burst_done <= 1'b0;
      prev_trans <= '0;
      prev_addr  <= '0;
      prev_burst <= '0;
      prev_size  <= '0;
      prev_write <= 1'b0;
      stall_q    <= 1'b0;
      err_valid  <= 1'b0;
      err_code   <= '0;
      err_addr   <= '0;
      exp_addr   <= '0;
      err_status <= '0;
    end else begin
      state      <= state_d;
      beats_left <= beats_left_d;
      lat_burst  <= lat_burst_d;
      lat_size   <= lat_size_d;
      lat_write  <= lat_write_d;
      exp_next   <= exp_next_d;
      burst_hi   <= burst_hi_d;
      beat_cnt   <= cnt_d;
      burst_done <= done_d;
      prev_trans <= Htrans;
      prev_addr  <= Haddr;
      prev_burst <= Hburst;
      prev_size  <= Hsize;
      prev_write <= Hwrite;
      stall_q    <= (Htrans != HTRANS_IDLE) && !Hreadyout;
      err_valid  <= |err_vec;
      if (|err_vec) begin
        err_code <= code_d;
        err_addr <= Haddr;
        exp_addr <= exp_next;
      end
      // New violations are ORed after the clear so they survive a same-cycle clear.
      err_status <= (clr_status ? 8'd0 : err_status) | err_vec;
    end
  end

endmodule

// File: tb/tb_ahb_burst_checker.sv
// tb/tb_ahb_burst_checker.sv - scoreboard testbench for ahb_burst_checker

module tb_ahb_burst_checker;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  localparam logic [1:0] TI = 2'd0, TB = 2'd1, TN = 2'd2, TS = 2'd3;
  localparam logic [2:0] B_SINGLE = 3'd0, B_INCR = 3'd1, B_WRAP4 = 3'd2, B_INCR4 = 3'd3,
                         B_WRAP8 = 3'd4, B_INCR16 = 3'd7;

  logic              clock = 1'b0;
  logic              Hresetn = 1'b1;
  logic [1:0]        Htrans = '0;
  logic [2:0]        Hburst = '0;
  logic [2:0]        Hsize = '0;
  logic [ADDR_W-1:0] Haddr = '0;
  logic              Hwrite = 1'b1;
  logic              Hreadyout = 1'b1;
  logic              clr_status = 1'b0;
  logic              err_valid;
  logic [2:0]        err_code;
  logic [ADDR_W-1:0] err_addr;
  logic [ADDR_W-1:0] exp_addr;
  logic [7:0]        err_status;
  logic              burst_done;
  logic [4:0]        beat_cnt;

  ahb_burst_checker #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock      (clock),
    .Hresetn    (Hresetn),
    .Htrans     (Htrans),
    .Hburst     (Hburst),
    .Hsize      (Hsize),
    .Haddr      (Haddr),
    .Hwrite     (Hwrite),
    .Hreadyout  (Hreadyout),
    .clr_status (clr_status),
    .err_valid  (err_valid),
    .err_code   (err_code),
    .err_addr   (err_addr),
    .exp_addr   (exp_addr),
    .err_status (err_status),
    .burst_done (burst_done),
    .beat_cnt   (beat_cnt)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic              ev;
    logic [2:0]        code;
    logic [ADDR_W-1:0] eaddr;
    logic [ADDR_W-1:0] xaddr;
    logic [7:0]        status;
    logic              done;
    logic [4:0]        cnt;
  } exp_t;

  exp_t              sb[$];
  int                n_checks = 0;
  int                n_fail = 0;
  int                step_no = 0;
  logic              wr = 1'b1;
  logic [2:0]        h_code = '0;
  logic [ADDR_W-1:0] h_eaddr = '0;
  logic [ADDR_W-1:0] h_xaddr = '0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string pfx, input exp_t e);
    check_eq({pfx, "_valid"},  64'(err_valid),  64'(e.ev));
    check_eq({pfx, "_code"},   64'(err_code),   64'(e.code));
    check_eq({pfx, "_eaddr"},  64'(err_addr),   64'(e.eaddr));
    check_eq({pfx, "_xaddr"},  64'(exp_addr),   64'(e.xaddr));
    check_eq({pfx, "_status"}, 64'(err_status), 64'(e.status));
    check_eq({pfx, "_done"},   64'(burst_done), 64'(e.done));
    check_eq({pfx, "_cnt"},    64'(beat_cnt),   64'(e.cnt));
  endtask

  // Drive one sample; the expected registered response is queued now and
  // compared once the following rising edge has produced it.
  task automatic step(input logic [1:0] tr, input logic [2:0] bu, input logic [2:0] sz,
                      input logic [ADDR_W-1:0] ad, input logic rdy, input logic clr,
                      input logic ev, input logic [2:0] code, input logic [ADDR_W-1:0] xaddr,
                      input logic done, input logic [4:0] cnt, input logic [7:0] status);
    exp_t e;
    @(negedge clock);
    Htrans     = tr;
    Hburst     = bu;
    Hsize      = sz;
    Haddr      = ad;
    Hwrite     = wr;
    Hreadyout  = rdy;
    clr_status = clr;
    if (ev) begin
      h_code  = code;
      h_eaddr = ad;
      h_xaddr = xaddr;
    end
    e = '{ev, h_code, h_eaddr, h_xaddr, status, done, cnt};
    sb.push_back(e);
    @(posedge clock);
    #1;
    step_no++;
    e = sb.pop_front();
    check_outputs($sformatf("s%0d", step_no), e);
  endtask

  task automatic do_reset(input string pfx);
    exp_t z;
    Htrans     = TI;
    Hburst     = B_SINGLE;
    Hsize      = 3'd0;
    Haddr      = '0;
    Hwrite     = 1'b1;
    Hreadyout  = 1'b1;
    clr_status = 1'b0;
    #1 Hresetn = 1'b0;
    #2;
    z = '{1'b0, 3'd0, '0, '0, 8'd0, 1'b0, 5'd0};
    check_outputs(pfx, z);
    h_code  = '0;
    h_eaddr = '0;
    h_xaddr = '0;
    @(negedge clock);
    Hresetn = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    do_reset("rst0");

    // WRAP4, size 2: 0x38, 0x3C, 0x30, 0x34
    step(TN, B_WRAP4, 3'd2, 32'h38, 1, 0,  0, 0, 0,  0, 5'd1, 8'h00);
    step(TS, B_WRAP4, 3'd2, 32'h3C, 1, 0,  0, 0, 0,  0, 5'd2, 8'h00);
    step(TS, B_WRAP4, 3'd2, 32'h30, 1, 0,  0, 0, 0,  0, 5'd3, 8'h00);
    step(TS, B_WRAP4, 3'd2, 32'h34, 1, 0,  0, 0, 0,  1, 5'd4, 8'h00);
    step(TI, B_SINGLE, 3'd0, 32'h0, 1, 0,  0, 0, 0,  0, 5'd4, 8'h00);

    // INCR4 cut short by IDLE after two SEQ beats
    step(TN, B_INCR4, 3'd2, 32'h100, 1, 0, 0, 0, 0,       0, 5'd1, 8'h00);
    step(TS, B_INCR4, 3'd2, 32'h104, 1, 0, 0, 0, 0,       0, 5'd2, 8'h00);
    step(TS, B_INCR4, 3'd2, 32'h108, 1, 0, 0, 0, 0,       0, 5'd3, 8'h00);
    step(TI, B_INCR4, 3'd2, 32'h10C, 1, 0, 1, 2, 32'h10C, 0, 5'd3, 8'h04);
    step(TI, B_SINGLE, 3'd0, 32'h0,  1, 0, 0, 0, 0,       0, 5'd3, 8'h04);

    // WRAP8 size 1 from 0x0E wraps to 0x00; 0x10 is wrong
    step(TN, B_WRAP8, 3'd1, 32'h0E, 1, 0, 0, 0, 0,     0, 5'd1, 8'h04);
    step(TS, B_WRAP8, 3'd1, 32'h10, 1, 0, 1, 3, 32'h0, 0, 5'd2, 8'h0C);
    do_reset("rst1");

    // SEQ with no burst open, illegal size, status clear behaviour
    step(TS, B_INCR,   3'd2, 32'h20, 1, 0, 1, 1, 32'h0,  0, 5'd0, 8'h02);
    step(TN, B_SINGLE, 3'd3, 32'h40, 1, 0, 1, 6, 32'h0,  1, 5'd1, 8'h42);
    step(TI, B_SINGLE, 3'd0, 32'h0,  1, 0, 0, 0, 0,      0, 5'd1, 8'h42);
    step(TS, B_INCR,   3'd2, 32'h24, 1, 1, 1, 1, 32'h48, 0, 5'd1, 8'h02);
    step(TI, B_SINGLE, 3'd0, 32'h0,  1, 1, 0, 0, 0,      0, 5'd1, 8'h00);

    // INCR across the 1 KB line, then stall instability and a wrong address
    step(TN, B_INCR, 3'd2, 32'h3FC, 1, 0, 0, 0, 0,       0, 5'd1, 8'h00);
    step(TS, B_INCR, 3'd2, 32'h400, 1, 0, 1, 7, 32'h400, 0, 5'd2, 8'h80);
    step(TS, B_INCR, 3'd2, 32'h404, 0, 0, 0, 0, 0,       0, 5'd2, 8'h80);
    step(TS, B_INCR, 3'd2, 32'h408, 0, 0, 1, 4, 32'h404, 0, 5'd2, 8'h90);
    step(TS, B_INCR, 3'd2, 32'h408, 1, 0, 1, 3, 32'h404, 0, 5'd3, 8'h98);
    step(TI, B_INCR, 3'd2, 32'h40C, 1, 0, 0, 0, 0,       0, 5'd3, 8'h98);

    // INCR16 with a BUSY cycle, a direction change on beat 5, then reset mid-burst
    step(TN, B_INCR16, 3'd2, 32'h200, 1, 0, 0, 0, 0, 0, 5'd1, 8'h98);
    step(TS, B_INCR16, 3'd2, 32'h204, 1, 0, 0, 0, 0, 0, 5'd2, 8'h98);
    step(TB, B_INCR16, 3'd2, 32'h208, 1, 0, 0, 0, 0, 0, 5'd2, 8'h98);
    step(TS, B_INCR16, 3'd2, 32'h208, 1, 0, 0, 0, 0, 0, 5'd3, 8'h98);
    step(TS, B_INCR16, 3'd2, 32'h20C, 1, 0, 0, 0, 0, 0, 5'd4, 8'h98);
    wr = 1'b0;
    step(TS, B_INCR16, 3'd2, 32'h210, 1, 0, 1, 4, 32'h210, 0, 5'd5, 8'h98);
    wr = 1'b1;
    do_reset("rst2");

    // after reset there is no open burst
    step(TS, B_INCR16, 3'd2, 32'h214, 1, 0, 1, 1, 32'h0, 0, 5'd0, 8'h02);
    step(TS, B_INCR16, 3'd2, 32'h218, 1, 0, 1, 1, 32'h0, 0, 5'd0, 8'h02);
    step(TI, B_SINGLE, 3'd0, 32'h0,   1, 0, 0, 0, 0,     0, 5'd0, 8'h02);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
